// File: rtl/rf_access_ctrl.sv
// Register-file access sequencer with a two-requester arbiter (core and debug port).
// Define RF_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (requester 0 wins).
module rf_access_ctrl #(
  parameter int AW      = 5,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          wr0,
  input  logic          wr1,
  input  logic [AW-1:0] raddr1_0,
  input  logic [AW-1:0] raddr2_0,
  input  logic [AW-1:0] raddr1_1,
  input  logic [AW-1:0] raddr2_1,
  input  logic [AW-1:0] waddr0,
  input  logic [AW-1:0] waddr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic          err,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2,
  output logic          busy,
  output logic          rf_re1,
  output logic          rf_re2,
  output logic          rf_we,
  output logic [AW-1:0] rf_raddr1,
  output logic [AW-1:0] rf_raddr2,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  input  logic [DW-1:0] rf_rdata1,
  input  logic [DW-1:0] rf_rdata2,
  input  logic          rf_read_finished,
  input  logic          rf_write_finished
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_WACK, S_DONE} state_t;

  localparam logic [3:0] TO_CNT = 4'(TIMEOUT);

  state_t        state_q, state_d;
  logic          gnt_q, gnt_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] raddr1_q, raddr1_d, raddr2_q, raddr2_d, waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d, rdata1_q, rdata1_d, rdata2_q, rdata2_d;
  logic          re_q, re_d, we_q, we_d;
  logic          ack0_q, ack0_d, ack1_q, ack1_d, err_q, err_d, busy_q, busy_d;

  logic          sel1;
  logic          wr_sel;
  logic [AW-1:0] ra1_sel, ra2_sel, wa_sel;
  logic [DW-1:0] wd_sel;

`ifdef RF_ARB_RR_EN
  // last_q records the most recent grant; reset value 1 hands the first tie to requester 0.
  logic last_q, last_d;

  always_comb begin
    if (req0 && req1) sel1 = ~last_q;
    else              sel1 = req1;
  end

  always_comb begin
    last_d = last_q;
    if (state_q == S_IDLE && (req0 || req1)) last_d = sel1;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end
`else
  always_comb sel1 = ~req0;
`endif

  assign wr_sel  = sel1 ? wr1      : wr0;
  assign ra1_sel = sel1 ? raddr1_1 : raddr1_0;
  assign ra2_sel = sel1 ? raddr2_1 : raddr2_0;
  assign wa_sel  = sel1 ? waddr1   : waddr0;
  assign wd_sel  = sel1 ? wdata1   : wdata0;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    raddr1_d = raddr1_q;
    raddr2_d = raddr2_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    rdata1_d = rdata1_q;
    rdata2_d = rdata2_q;
    re_d     = 1'b0;
    we_d     = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          gnt_d    = sel1;
          raddr1_d = ra1_sel;
          raddr2_d = ra2_sel;
          waddr_d  = wa_sel;
          wdata_d  = wd_sel;
          if (!wr_sel) begin
            state_d = S_READ;
            re_d    = 1'b1;
            cnt_d   = 4'd0;
          end else if (wa_sel == '0) begin
            // Register 0 is hard-wired; acknowledge without touching the file.
            state_d = S_DONE;
          end else begin
            state_d = S_WRITE;
            we_d    = 1'b1;
          end
        end
      end
      S_READ: begin
        if (rf_read_finished) begin
          rdata1_d = rf_rdata1;
          rdata2_d = rf_rdata2;
          state_d  = S_DONE;
        end else if (cnt_q == TO_CNT) begin
          rdata1_d = '0;
          rdata2_d = '0;
          err_d    = 1'b1;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
          re_d  = 1'b1;
        end
      end
      S_WRITE: begin
        state_d = S_WACK;
        cnt_d   = 4'd0;
      end
      S_WACK: begin
        if (rf_write_finished) begin
          state_d = S_DONE;
        end else if (cnt_q == TO_CNT) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ack0_d = (state_d == S_DONE) && (state_q != S_DONE) && !gnt_d;
    ack1_d = (state_d == S_DONE) && (state_q != S_DONE) &&  gnt_d;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      gnt_q    <= 1'b0;
      cnt_q    <= 4'd0;
      raddr1_q <= '0;
      raddr2_q <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      re_q     <= 1'b0;
      we_q     <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      raddr1_q <= raddr1_d;
      raddr2_q <= raddr2_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
      re_q     <= re_d;
      we_q     <= we_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign err       = err_q;
  assign rdata1    = rdata1_q;
  assign rdata2    = rdata2_q;
  assign busy      = busy_q;
  assign rf_re1    = re_q;
  assign rf_re2    = re_q;
  assign rf_we     = we_q;
  assign rf_raddr1 = raddr1_q;
  assign rf_raddr2 = raddr2_q;
  assign rf_waddr  = waddr_q;
  assign rf_wdata  = wdata_q;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Bench for rf_access_ctrl: behavioural register file plus a scoreboard of expected acknowledges.
module tb_rf_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, wr0, wr1;
  logic [4:0]  raddr1_0, raddr2_0, raddr1_1, raddr2_1, waddr0, waddr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1, err, busy, rf_re1, rf_re2, rf_we;
  logic [31:0] rdata1, rdata2, rf_wdata;
  logic [4:0]  rf_raddr1, rf_raddr2, rf_waddr;
  logic [31:0] rf_rdata1 = '0, rf_rdata2 = '0;
  logic        rf_read_finished = 1'b0, rf_write_finished = 1'b0;

  logic [31:0] mem [32];
  bit          hang_rd = 1'b0, hang_wr = 1'b0;

  typedef struct {
    bit          who;
    bit          err;
    logic [31:0] d1;
    logic [31:0] d2;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rf_access_ctrl dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .raddr1_0(raddr1_0), .raddr2_0(raddr2_0), .raddr1_1(raddr1_1), .raddr2_1(raddr2_1),
    .waddr0(waddr0), .waddr1(waddr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err(err), .rdata1(rdata1), .rdata2(rdata2), .busy(busy),
    .rf_re1(rf_re1), .rf_re2(rf_re2), .rf_we(rf_we),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_read_finished(rf_read_finished), .rf_write_finished(rf_write_finished)
  );

  // Register file: reads on the falling edge, commits writes on the rising edge.
  always @(negedge clk) begin
    if (rf_re1 && rf_re2 && !hang_rd) begin
      rf_rdata1        <= mem[rf_raddr1];
      rf_rdata2        <= mem[rf_raddr2];
      rf_read_finished <= 1'b1;
    end else begin
      rf_read_finished <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rf_we) mem[rf_waddr] <= rf_wdata;
    rf_write_finished <= rf_we && !hang_wr;
  end

  task automatic drive(input bit who, input bit wr, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] wa, input logic [31:0] wd);
    if (who) begin
      req1 = 1'b1; wr1 = wr; raddr1_1 = a1; raddr2_1 = a2; waddr1 = wa; wdata1 = wd;
    end else begin
      req0 = 1'b1; wr0 = wr; raddr1_0 = a1; raddr2_0 = a2; waddr0 = wa; wdata0 = wd;
    end
  endtask

  // Counts falling edges from the drive cycle (0) until an ack appears, tallying enable cycles.
  task automatic wait_ack(input int max, output int lat, output bit got, output int re_n, output int we_n);
    lat = -1; got = 1'b0; re_n = 0; we_n = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (rf_re1) re_n++;
      if (rf_we)  we_n++;
      if (ack0 || ack1) begin
        lat = i; got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
    raddr1_0 = 0; raddr2_0 = 0; raddr1_1 = 0; raddr2_1 = 0;
    waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if ({ack0, ack1, err} !== 3'b000) begin n_fail++; $display("FAIL reset_ack_err: got %b expected 000", {ack0, ack1, err}); end
    n_tests++; if ({rf_re1, rf_re2, rf_we} !== 3'b000) begin n_fail++; $display("FAIL reset_enables: got %b expected 000", {rf_re1, rf_re2, rf_we}); end
    n_tests++; if ({rdata1, rdata2} !== 64'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", {rdata1, rdata2}); end
    n_tests++; if ({rf_raddr1, rf_raddr2, rf_waddr, rf_wdata} !== 47'h0) begin n_fail++; $display("FAIL reset_rf_bus: got %h expected 0", {rf_raddr1, rf_raddr2, rf_waddr, rf_wdata}); end
    rst = 1'b0;
  endtask

  // One read or write transaction by a single requester, checked against the scoreboard.
  task automatic do_txn(input string nm, input bit who, input bit wr, input logic [4:0] a1,
                        input logic [4:0] a2, input logic [4:0] wa, input logic [31:0] wd,
                        input int exp_re, input int exp_we);
    int lat, re_n, we_n; bit got; exp_t e;
    @(posedge clk); #1;
    drive(who, wr, a1, a2, wa, wd);
    wait_ack(40, lat, got, re_n, we_n);
    e = sb.pop_front();
    n_tests++; if (got !== 1'b1) begin n_fail++; $display("FAIL %s_ack_seen: got %b expected 1", nm, got); end
    n_tests++; if (lat !== e.lat) begin n_fail++; $display("FAIL %s_latency: got %0d expected %0d", nm, lat, e.lat); end
    n_tests++; if ({ack1, ack0} !== (e.who ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL %s_who: got %b expected %b", nm, {ack1, ack0}, (e.who ? 2'b10 : 2'b01)); end
    n_tests++; if (err !== e.err) begin n_fail++; $display("FAIL %s_err: got %b expected %b", nm, err, e.err); end
    n_tests++; if ({rdata1, rdata2} !== {e.d1, e.d2}) begin n_fail++; $display("FAIL %s_rdata: got %h expected %h", nm, {rdata1, rdata2}, {e.d1, e.d2}); end
    n_tests++; if (re_n !== exp_re) begin n_fail++; $display("FAIL %s_re_cycles: got %0d expected %0d", nm, re_n, exp_re); end
    n_tests++; if (we_n !== exp_we) begin n_fail++; $display("FAIL %s_we_cycles: got %0d expected %0d", nm, we_n, exp_we); end
    if (who) req1 = 1'b0; else req0 = 1'b0;
  endtask

  task automatic test_read;
    sb.push_back('{who: 1'b0, err: 1'b0, d1: 32'h11, d2: 32'h22, lat: 2});
    do_txn("read0", 1'b0, 1'b0, 5'd3, 5'd7, 5'd0, 32'h0, 1, 0);
  endtask

  task automatic test_write;
    sb.push_back('{who: 1'b1, err: 1'b0, d1: 32'h11, d2: 32'h22, lat: 3});
    do_txn("write1", 1'b1, 1'b1, 5'd0, 5'd0, 5'd9, 32'hDEADBEEF, 0, 1);
    sb.push_back('{who: 1'b0, err: 1'b0, d1: 32'hDEADBEEF, d2: 32'h11, lat: 2});
    do_txn("readback9", 1'b0, 1'b0, 5'd9, 5'd3, 5'd0, 32'h0, 1, 0);
  endtask

  task automatic test_write_zero;
    sb.push_back('{who: 1'b0, err: 1'b0, d1: 32'hDEADBEEF, d2: 32'h11, lat: 1});
    do_txn("write_r0", 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 0, 0);
    sb.push_back('{who: 1'b1, err: 1'b0, d1: 32'h5A5A0000, d2: 32'h22, lat: 2});
    do_txn("read_r0", 1'b1, 1'b0, 5'd0, 5'd7, 5'd0, 32'h0, 1, 0);
  endtask

  task automatic test_back_to_back;
    int lat, re_n, we_n; bit got; exp_t e;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
`ifdef RF_ARB_RR_EN
      if (k % 2 == 1) sb.push_back('{who: 1'b1, err: 1'b0, d1: 32'hDEADBEEF, d2: 32'h5A5A0000, lat: 2});
      else            sb.push_back('{who: 1'b0, err: 1'b0, d1: 32'h11, d2: 32'h22, lat: 2});
`else
      sb.push_back('{who: 1'b0, err: 1'b0, d1: 32'h11, d2: 32'h22, lat: 2});
`endif
    end
    drive(1'b0, 1'b0, 5'd3, 5'd7, 5'd0, 32'h0);
    drive(1'b1, 1'b0, 5'd9, 5'd0, 5'd0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      wait_ack(20, lat, got, re_n, we_n);
      e = sb.pop_front();
      n_tests++; if ({got, lat} !== {1'b1, e.lat}) begin n_fail++; $display("FAIL b2b%0d_latency: got %b/%0d expected 1/%0d", k, got, lat, e.lat); end
      n_tests++; if ({ack1, ack0} !== (e.who ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL b2b%0d_who: got %b expected %b", k, {ack1, ack0}, (e.who ? 2'b10 : 2'b01)); end
      n_tests++; if ({rdata1, rdata2} !== {e.d1, e.d2}) begin n_fail++; $display("FAIL b2b%0d_rdata: got %h expected %h", k, {rdata1, rdata2}, {e.d1, e.d2}); end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_timeout;
    hang_rd = 1'b1;
    sb.push_back('{who: 1'b0, err: 1'b1, d1: 32'h0, d2: 32'h0, lat: 17});
    do_txn("rd_timeout", 1'b0, 1'b0, 5'd3, 5'd7, 5'd0, 32'h0, 16, 0);
    hang_rd = 1'b0;
    @(negedge clk);
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL timeout_err_pulse: got %b expected 0", err); end
  endtask

  task automatic test_reset_in_wack;
    int acks = 0;
    hang_wr = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 5'd0, 5'd0, 5'd12, 32'hCAFEF00D);
    repeat (3) @(negedge clk);
    n_tests++; if ({busy, rf_we} !== 2'b10) begin n_fail++; $display("FAIL wack_state: got busy/we %b expected 10", {busy, rf_we}); end
    rst = 1'b1; req1 = 1'b0;
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wack_rst_busy: got %b expected 0", busy); end
    rst = 1'b0; hang_wr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (ack0 || ack1 || err) acks++;
      @(negedge clk);
    end
    n_tests++; if (acks !== 0) begin n_fail++; $display("FAIL wack_rst_no_ack: got %0d acks expected 0", acks); end
    n_tests++; if (mem[12] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL wack_rst_commit: got %h expected cafef00d", mem[12]); end
    sb.push_back('{who: 1'b0, err: 1'b0, d1: 32'hCAFEF00D, d2: 32'h11, lat: 2});
    do_txn("read_r12", 1'b0, 1'b0, 5'd12, 5'd3, 5'd0, 32'h0, 1, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000 + i;
    mem[0] = 32'h5A5A0000;
    mem[3] = 32'h11;
    mem[7] = 32'h22;
    test_reset();
    test_read();
    test_write();
    test_write_zero();
    test_back_to_back();
    test_timeout();
    test_reset_in_wack();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
